// File: rtl/datapath_if.sv
// Control/memory bundle between the Lab B control unit, data RAM and datapath.
// master = control unit + RAM side, slave = datapath.
interface datapath_if #(
  parameter int DW  = 16,
  parameter int RAW = 4,
  parameter int DAW = 8
);
  logic [DAW-1:0] D_addr;
  logic           D_wr;
  logic           RF_s;
  logic [RAW-1:0] RF_W_addr;
  logic           RF_W_wr;
  logic [RAW-1:0] RF_Ra_addr;
  logic           RF_Ra_rd;
  logic [RAW-1:0] RF_Rb_addr;
  logic           RF_Rb_rd;
  logic [2:0]     Alu_s0;
  logic [DW-1:0]  M_rdata;
  logic [DAW-1:0] M_addr;
  logic [DW-1:0]  M_wdata;
  logic           M_wr;
  logic [DW-1:0]  Ra_data;
  logic [DW-1:0]  Rb_data;
  logic [DW-1:0]  ALU_Out;
  logic           Zero;

  modport master (
    output D_addr, D_wr, RF_s, RF_W_addr, RF_W_wr, RF_Ra_addr, RF_Ra_rd,
           RF_Rb_addr, RF_Rb_rd, Alu_s0, M_rdata,
    input  M_addr, M_wdata, M_wr, Ra_data, Rb_data, ALU_Out, Zero
  );

  modport slave (
    input  D_addr, D_wr, RF_s, RF_W_addr, RF_W_wr, RF_Ra_addr, RF_Ra_rd,
           RF_Rb_addr, RF_Rb_rd, Alu_s0, M_rdata,
    output M_addr, M_wdata, M_wr, Ra_data, Rb_data, ALU_Out, Zero
  );
endinterface

// File: rtl/datapath.sv
// Lab B execution datapath: 2**RAW x DW register file, 8-function ALU,
// write-back mux and data-RAM interface, plus a registered Zero flag.
module datapath #(
  parameter int DW  = 16,
  parameter int RAW = 4,
  parameter int DAW = 8
) (
  input  logic        Clock,
  input  logic        Reset,
  datapath_if.slave   bus
);
  localparam int NREG = 1 << RAW;

  logic [NREG-1:0][DW-1:0] rf;
  logic [DW-1:0]           ra, rb, alu, w_data;
  logic                    zero_q;

  // Reads are combinational and unbypassed: a same-edge write shows up next cycle.
  assign ra = bus.RF_Ra_rd ? rf[bus.RF_Ra_addr] : '0;
  assign rb = bus.RF_Rb_rd ? rf[bus.RF_Rb_addr] : '0;

  always_comb begin
    alu = '0;
    case (bus.Alu_s0)
      3'd0:    alu = '0;
      3'd1:    alu = ra + rb;
      3'd2:    alu = ra - rb;
      3'd3:    alu = ra;
      3'd4:    alu = ra ^ rb;
      3'd5:    alu = ra | rb;
      3'd6:    alu = ra & rb;
      default: alu = ra + DW'(1);
    endcase
  end

  assign w_data = bus.RF_s ? bus.M_rdata : alu;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      rf <= '0;
    end else if (bus.RF_W_wr) begin
      rf[bus.RF_W_addr] <= w_data;
    end
  end

  // Only ALU write-backs update Zero; loads leave it alone.
  always_ff @(posedge Clock) begin
    if (Reset)
      zero_q <= 1'b0;
    else if (bus.RF_W_wr && !bus.RF_s)
      zero_q <= (alu == '0);
  end

  assign bus.M_addr  = bus.D_addr;
  assign bus.M_wr    = bus.D_wr;
  assign bus.M_wdata = ra;
  assign bus.Ra_data = ra;
  assign bus.Rb_data = rb;
  assign bus.ALU_Out = alu;
  assign bus.Zero    = zero_q;
endmodule

// File: tb/tb_datapath.sv
// Directed bench for datapath: register-level model of the spec, a per-cycle
// comparator, a registered RAM model, and literal expectations per scenario.
module tb_datapath;
  logic clk = 1'b0;
  logic rst;
  int   n_pass = 0;
  int   n_total = 0;
  logic chk_en = 1'b0;

  datapath_if #(.DW(16), .RAW(4), .DAW(8)) dp_if ();
  datapath #(.DW(16), .RAW(4), .DAW(8)) dut (.Clock(clk), .Reset(rst), .bus(dp_if.slave));

  always #5 clk = ~clk;

  // Data RAM: registered read, 1-cycle latency.
  logic [15:0] ram [256];
  always @(posedge clk) begin
    if (dp_if.M_wr) ram[dp_if.M_addr] <= dp_if.M_wdata;
    dp_if.M_rdata <= ram[dp_if.M_addr];
  end

  // Reference model state.
  logic [15:0] m_rf [16];
  logic        m_zero;

  function automatic logic [15:0] f_alu(input logic [2:0] s, input logic [15:0] a, input logic [15:0] b);
    int x;
    x = 0;
    case (s)
      3'd1: x = int'(a) + int'(b);
      3'd2: x = int'(a) - int'(b) + 65536;
      3'd3: x = int'(a);
      3'd4: x = int'(a ^ b);
      3'd5: x = int'(a | b);
      3'd6: x = int'(a & b);
      3'd7: x = int'(a) + 1;
      default: x = 0;
    endcase
    return 16'(x % 65536);
  endfunction

  function automatic logic [15:0] m_a();
    return dp_if.RF_Ra_rd ? m_rf[dp_if.RF_Ra_addr] : 16'h0;
  endfunction
  function automatic logic [15:0] m_b();
    return dp_if.RF_Rb_rd ? m_rf[dp_if.RF_Rb_addr] : 16'h0;
  endfunction

  always @(posedge clk) begin
    logic [15:0] r;
    if (rst) begin
      for (int i = 0; i < 16; i++) m_rf[i] = 16'h0;
      m_zero = 1'b0;
    end else if (dp_if.RF_W_wr) begin
      r = f_alu(dp_if.Alu_s0, m_a(), m_b());
      if (dp_if.RF_s) m_rf[dp_if.RF_W_addr] = dp_if.M_rdata;
      else begin
        m_rf[dp_if.RF_W_addr] = r;
        m_zero = (r == 16'h0);
      end
    end
  end

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cmp Ra_data", dp_if.Ra_data, m_a());
      chk("cmp Rb_data", dp_if.Rb_data, m_b());
      chk("cmp ALU_Out", dp_if.ALU_Out, f_alu(dp_if.Alu_s0, m_a(), m_b()));
      chk("cmp M_addr",  16'(dp_if.M_addr), 16'(dp_if.D_addr));
      chk("cmp M_wdata", dp_if.M_wdata, m_a());
      chk("cmp M_wr",    16'(dp_if.M_wr), 16'(dp_if.D_wr));
      chk("cmp Zero",    16'(dp_if.Zero), 16'(m_zero));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    dp_if.D_addr = '0;     dp_if.D_wr = 1'b0;     dp_if.RF_s = 1'b0;
    dp_if.RF_W_addr = '0;  dp_if.RF_W_wr = 1'b0;
    dp_if.RF_Ra_addr = '0; dp_if.RF_Ra_rd = 1'b0;
    dp_if.RF_Rb_addr = '0; dp_if.RF_Rb_rd = 1'b0;
    dp_if.Alu_s0 = '0;
  endtask

  task automatic load(input logic [7:0] ma, input logic [3:0] rd);
    idle(); dp_if.D_addr = ma; cyc();
    idle(); dp_if.RF_s = 1'b1; dp_if.RF_W_addr = rd; dp_if.RF_W_wr = 1'b1; cyc();
    idle();
  endtask

  task automatic op(input logic [2:0] s, input logic [3:0] a, input logic [3:0] b, input logic [3:0] w);
    idle();
    dp_if.Alu_s0 = s;
    dp_if.RF_Ra_addr = a; dp_if.RF_Ra_rd = 1'b1;
    dp_if.RF_Rb_addr = b; dp_if.RF_Rb_rd = 1'b1;
    dp_if.RF_W_addr = w;  dp_if.RF_W_wr = 1'b1;
  endtask

  task automatic rd2(input logic [3:0] a, input logic [3:0] b);
    idle();
    dp_if.RF_Ra_addr = a; dp_if.RF_Ra_rd = 1'b1;
    dp_if.RF_Rb_addr = b; dp_if.RF_Rb_rd = 1'b1;
  endtask

  logic [15:0] alu_tab [8];

  initial begin
    for (int i = 0; i < 256; i++) ram[i] <= 16'h0;
    ram[8'h1B] <= 16'h00A5;
    ram[8'h10] <= 16'hFFFF;
    ram[8'h11] <= 16'h0001;
    ram[8'h12] <= 16'h7777;
    ram[8'h20] <= 16'h0042;
    ram[8'h21] <= 16'h1234;
    ram[8'h22] <= 16'hBEEF;
    ram[8'h23] <= 16'h5555;
    alu_tab[0] = 16'h0000; alu_tab[1] = 16'hBEEE; alu_tab[2] = 16'h4110; alu_tab[3] = 16'hFFFF;
    alu_tab[4] = 16'h4110; alu_tab[5] = 16'hFFFF; alu_tab[6] = 16'hBEEF; alu_tab[7] = 16'h0000;
    rst = 1'b1;
    idle();
    cyc();
    rst = 1'b0;
    chk_en = 1'b1;

    // Reset state on every register, both ports.
    for (int i = 0; i < 16; i++) begin
      rd2(4'(i), 4'(15 - i));
      @(negedge clk);
      chk("reset Ra", dp_if.Ra_data, 16'h0);
      chk("reset Rb", dp_if.Rb_data, 16'h0);
      chk("reset Zero", 16'(dp_if.Zero), 16'h0);
      cyc();
    end

    // LOAD into reg3.
    load(8'h1B, 4'd3);
    rd2(4'd3, 4'd3);
    @(negedge clk);
    chk("load reg3", dp_if.Ra_data, 16'h00A5);
    chk("load reg3 B", dp_if.Rb_data, 16'h00A5);
    cyc();

    // ADD wrap and SUB, Zero behaviour.
    load(8'h10, 4'd1);
    load(8'h11, 4'd2);
    op(3'd1, 4'd1, 4'd2, 4'd4);
    @(negedge clk);
    chk("add wrap ALU", dp_if.ALU_Out, 16'h0000);
    cyc();
    rd2(4'd4, 4'd1);
    @(negedge clk);
    chk("add reg4", dp_if.Ra_data, 16'h0000);
    chk("add Zero", 16'(dp_if.Zero), 16'h1);
    cyc();
    load(8'h12, 4'd10);
    @(negedge clk);
    chk("load keeps Zero", 16'(dp_if.Zero), 16'h1);
    cyc();
    op(3'd2, 4'd2, 4'd2, 4'd6);
    cyc();
    idle();
    @(negedge clk);
    chk("sub self Zero", 16'(dp_if.Zero), 16'h1);
    cyc();
    op(3'd2, 4'd1, 4'd2, 4'd8);
    @(negedge clk);
    chk("sub ALU", dp_if.ALU_Out, 16'hFFFE);
    cyc();
    rd2(4'd8, 4'd6);
    @(negedge clk);
    chk("sub reg8", dp_if.Ra_data, 16'hFFFE);
    chk("sub Zero", 16'(dp_if.Zero), 16'h0);
    cyc();

    // Same-cycle write/read of reg5: old value, then new, then disabled port.
    load(8'h20, 4'd5);
    dp_if.D_addr = 8'h21;
    cyc();
    idle();
    dp_if.RF_s = 1'b1; dp_if.RF_W_addr = 4'd5; dp_if.RF_W_wr = 1'b1;
    dp_if.RF_Ra_addr = 4'd5; dp_if.RF_Ra_rd = 1'b1;
    @(negedge clk);
    chk("rw same cycle old", dp_if.Ra_data, 16'h0042);
    cyc();
    rd2(4'd5, 4'd5);
    @(negedge clk);
    chk("rw next cycle A", dp_if.Ra_data, 16'h1234);
    chk("rw next cycle B", dp_if.Rb_data, 16'h1234);
    cyc();
    dp_if.RF_Ra_rd = 1'b0;
    @(negedge clk);
    chk("rd disabled", dp_if.Ra_data, 16'h0000);
    cyc();

    // STORE reg7 to 0x80 and read it back.
    load(8'h22, 4'd7);
    rd2(4'd7, 4'd0);
    dp_if.D_addr = 8'h80; dp_if.D_wr = 1'b1;
    @(negedge clk);
    chk("store M_wr", 16'(dp_if.M_wr), 16'h1);
    chk("store M_wdata", dp_if.M_wdata, 16'hBEEF);
    chk("store M_addr", 16'(dp_if.M_addr), 16'h0080);
    cyc();
    load(8'h80, 4'd11);
    rd2(4'd11, 4'd7);
    @(negedge clk);
    chk("store readback", dp_if.Ra_data, 16'hBEEF);
    cyc();

    // All ALU functions with A=0xFFFF, B=0xBEEF.
    for (int s = 0; s < 8; s++) begin
      op(3'(s), 4'd1, 4'd7, 4'd13);
      @(negedge clk);
      chk($sformatf("alu fn%0d", s), dp_if.ALU_Out, alu_tab[s]);
      cyc();
    end

    // Reset in the same cycle as a load write to reg9.
    idle();
    dp_if.D_addr = 8'h23;
    cyc();
    idle();
    rst = 1'b1;
    dp_if.RF_s = 1'b1; dp_if.RF_W_addr = 4'd9; dp_if.RF_W_wr = 1'b1;
    cyc();
    rst = 1'b0;
    rd2(4'd9, 4'd7);
    @(negedge clk);
    chk("reset drops write", dp_if.Ra_data, 16'h0000);
    chk("reset clears reg7", dp_if.Rb_data, 16'h0000);
    chk("reset Zero clr", 16'(dp_if.Zero), 16'h0);
    cyc();
    idle();
    cyc();

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
